// File: rtl/dme_pkg.sv
// Shared definitions for the DME power/reset sequencer.
// Provides the per-slot state encoding, the DMEControl bit layout and two
// helpers: max3() sizes the slot counters, and pack_ctrl() builds one slot's
// control field from its state.
package dme_pkg;

  // Each state's numeric code is placed directly in DMEControl bits 3:1.
  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_EN   = 3'd1,
    ST_PG_DEB   = 3'd2,
    ST_RST_HOLD = 3'd3,
    ST_RUN      = 3'd4,
    ST_FAULT    = 3'd5
  } slot_state_t;

  localparam int CTRL_W        = 6;
  localparam int CTRL_PWR_EN   = 0;
  localparam int CTRL_CODE_LSB = 1;
  localparam int CTRL_CODE_MSB = 3;
  localparam int CTRL_FAULT    = 4;
  localparam int CTRL_ID_VALID = 5;
  localparam int ID_W          = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Builds the control field for a slot. Power stays enabled from PWR_EN
  // through RUN. It is off in OFF and in FAULT.
  function automatic logic [CTRL_W-1:0] pack_ctrl(input slot_state_t st,
                                                  input logic        id_valid);
    logic [CTRL_W-1:0] c;
    c                               = '0;
    c[CTRL_PWR_EN]                  = (st inside {ST_PWR_EN, ST_PG_DEB,
                                                  ST_RST_HOLD, ST_RUN});
    c[CTRL_CODE_MSB:CTRL_CODE_LSB]  = st;
    c[CTRL_FAULT]                   = (st == ST_FAULT);
    c[CTRL_ID_VALID]                = id_valid;
    return c;
  endfunction

endpackage

// File: rtl/dme_slot_fsm.sv
// Power-up and reset sequencer for a single DME slot.
// All inputs are already synchronised to clk.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ps_ok, plt_ok            system power OK, platform reset released
//   pg, absent               slot power good, slot empty
//   id[3:0]                  slot ID, captured when the slot enters RUN
//   rst_n                    registered slot reset, low active
//   ctrl[5:0]                registered {id_valid, fault, state[2:0], pwr_en}
//   id_latched[3:0]          registered ID captured on entry to RUN
module dme_slot_fsm
  import dme_pkg::*;
#(
  parameter int DEB_CYCLES     = 32,
  parameter int RST_DLY_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps_ok,
  input  logic              plt_ok,
  input  logic              pg,
  input  logic              absent,
  input  logic [ID_W-1:0]   id,
  output logic              rst_n,
  output logic [CTRL_W-1:0] ctrl,
  output logic [ID_W-1:0]   id_latched
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_DLY_CYCLES - 1);

  slot_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              id_valid, id_valid_nxt;
  logic [ID_W-1:0]   id_nxt;
  logic [CTRL_W-1:0] ctrl_nxt;
  logic              rst_n_nxt;

  // The counter saturates at all-ones instead of wrapping back to zero.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // NOTE: every signal written here is given a default first. A path that
  // left one of them unassigned would infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    id_nxt       = id_latched;
    id_valid_nxt = id_valid;

    if (absent || !ps_ok) begin
      state_nxt = ST_OFF;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_OFF: begin
          state_nxt = ST_PWR_EN;
          cnt_nxt   = '0;
        end
        ST_PWR_EN: begin
          if (pg) begin
            state_nxt = ST_PG_DEB;
            cnt_nxt   = '0;
          end else if (cnt == TO_LAST) begin
            state_nxt = ST_FAULT;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        ST_PG_DEB: begin
          if (!pg) begin
            state_nxt = ST_PWR_EN;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt = ST_RST_HOLD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        ST_RST_HOLD: begin
          if (!pg) begin
            state_nxt = ST_FAULT;
          end else if (!plt_ok) begin
            // The reset delay starts over whenever the platform re-enters reset.
            cnt_nxt = '0;
          end else if (cnt == RST_LAST) begin
            state_nxt    = ST_RUN;
            cnt_nxt      = '0;
            id_nxt       = id;
            id_valid_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        ST_RUN: begin
          if (!pg) begin
            state_nxt = ST_FAULT;
          end else if (!plt_ok) begin
            state_nxt = ST_RST_HOLD;
            cnt_nxt   = '0;
          end
        end
        ST_FAULT: begin
          // FAULT is sticky. Only absent or a power-OK drop (handled above)
          // returns the slot to OFF.
        end
        default: begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end
      endcase
    end

    if (state_nxt == ST_OFF) begin
      id_nxt       = '0;
      id_valid_nxt = 1'b0;
    end

    // The outputs are decoded from the next state and then registered, so
    // they change on the same edge as the state and never glitch.
    ctrl_nxt  = pack_ctrl(state_nxt, id_valid_nxt);
    rst_n_nxt = (state_nxt == ST_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_OFF;
      cnt        <= '0;
      id_valid   <= 1'b0;
      id_latched <= '0;
      ctrl       <= '0;
      rst_n      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      id_valid   <= id_valid_nxt;
      id_latched <= id_nxt;
      ctrl       <= ctrl_nxt;
      rst_n      <= rst_n_nxt;
    end
  end

endmodule

// File: rtl/dme_init_seq.sv
// Sequences power enable, power-good debounce and reset release for up to
// four DME slots. Each slot has its own independent FSM.
// Ports:
//   CLK_32KHZ               sole clock, rising edge
//   RST_SYNC                synchronous active-high reset
//   PWRGD_PS_PWROK_3V3      async system power OK
//   RST_PLTRST_N            async platform reset, low active
//   DME_PWRGD[N-1:0]        async per-slot power good
//   DME_Absent[N-1:0]       async per-slot empty indication
//   DMEID[4N-1:0]           slot IDs, slot n at [4n+3:4n]
//   RST_DME_N[N-1:0]        per-slot reset, low active
//   DMEControl[6N-1:0]      per-slot {id_valid, fault, state[2:0], pwr_en}
//   DMEIDLatched[4N-1:0]    per-slot ID captured on entry to RUN
module dme_init_seq
  import dme_pkg::*;
#(
  parameter int NUM_DME        = 2,
  parameter int DEB_CYCLES     = 32,
  parameter int RST_DLY_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      CLK_32KHZ,
  input  logic                      RST_SYNC,
  input  logic                      PWRGD_PS_PWROK_3V3,
  input  logic                      RST_PLTRST_N,
  input  logic [NUM_DME-1:0]        DME_PWRGD,
  input  logic [NUM_DME-1:0]        DME_Absent,
  input  logic [ID_W*NUM_DME-1:0]   DMEID,
  output logic [NUM_DME-1:0]        RST_DME_N,
  output logic [CTRL_W*NUM_DME-1:0] DMEControl,
  output logic [ID_W*NUM_DME-1:0]   DMEIDLatched
);

  localparam int CNT_W  = $clog2(max3(DEB_CYCLES, RST_DLY_CYCLES,
                                      TIMEOUT_CYCLES) + 1);
  localparam int SYNC_W = 2 + 2 * NUM_DME;

  logic [SYNC_W-1:0]  sync_in, sync1, sync2;
  logic               ps_ok, plt_ok;
  logic [NUM_DME-1:0] pg, absent;

  assign sync_in = {DME_Absent, DME_PWRGD, RST_PLTRST_N, PWRGD_PS_PWROK_3V3};

  // Two-flop synchronisers for every asynchronous input. The reset value of
  // zero keeps all slots in OFF until power OK has passed through both stages.
  always_ff @(posedge CLK_32KHZ) begin
    if (RST_SYNC) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sync_in;
      sync2 <= sync1;
    end
  end

  assign ps_ok  = sync2[0];
  assign plt_ok = sync2[1];
  assign pg     = sync2[2 +: NUM_DME];
  assign absent = sync2[2 + NUM_DME +: NUM_DME];

  for (genvar n = 0; n < NUM_DME; n++) begin : g_slot
    dme_slot_fsm #(
      .DEB_CYCLES     (DEB_CYCLES),
      .RST_DLY_CYCLES (RST_DLY_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
    ) u_slot (
      .clk        (CLK_32KHZ),
      .rst        (RST_SYNC),
      .ps_ok      (ps_ok),
      .plt_ok     (plt_ok),
      .pg         (pg[n]),
      .absent     (absent[n]),
      .id         (DMEID[ID_W*n +: ID_W]),
      .rst_n      (RST_DME_N[n]),
      .ctrl       (DMEControl[CTRL_W*n +: CTRL_W]),
      .id_latched (DMEIDLatched[ID_W*n +: ID_W])
    );
  end

endmodule

// File: doc/dme_init_seq.md
DME_INIT_SEQ -- requirements
Module: dme_init_seq

Interface
REQ-001 SHALL have parameter NUM_DME, default 2, number of DME slots (1..4).
REQ-002 SHALL have parameter DEB_CYCLES, default 32, count of consecutive DME_PWRGD-high cycles needed to declare power good.
REQ-003 SHALL have parameter RST_DLY_CYCLES, default 64, cycles RST_DME_N stays low after synchronised platform reset release.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles from power enable to DME_PWRGD high.
REQ-005 SHALL be timed by one clock with a synchronous, active-high reset: CLK_32KHZ  in  1  sole clock, all logic on rising edge.
REQ-006 RST_SYNC  in  1  synchronous active-high reset.
REQ-007 PWRGD_PS_PWROK_3V3  in  1  asynchronous system power OK.
REQ-008 RST_PLTRST_N  in  1  asynchronous platform reset, low active.
REQ-009 DME_PWRGD  in  NUM_DME  asynchronous per-slot power good.
REQ-010 DME_Absent  in  NUM_DME  asynchronous, high = slot empty.
REQ-011 DMEID  in  4*NUM_DME  slot ID, 4 bits per slot, slot n at [4n+3:4n].
REQ-012 RST_DME_N  out  NUM_DME  per-slot reset, low active.
REQ-013 DMEControl  out  6*NUM_DME  per slot: bit0 PWR_EN, bits3:1 state code, bit4 fault, bit5 ID valid.
REQ-014 DMEIDLatched  out  4*NUM_DME  per-slot ID captured on entry to RUN.

Function
REQ-015 SHALL pass PWRGD_PS_PWROK_3V3, RST_PLTRST_N, DME_PWRGD, DME_Absent through 2-flop synchronisers; all decisions use synchronised values (ps_ok, plt_ok, pg[n], abs[n]).
REQ-016 SHALL run one independent FSM per slot: OFF=0, PWR_EN=1, PG_DEB=2, RST_HOLD=3, RUN=4, FAULT=5; code drives DMEControl bits3:1.
REQ-017 Priority each cycle: RST_SYNC > (abs[n]=1 or ps_ok=0 -> OFF) > state transitions below.
REQ-018 OFF -> PWR_EN when abs[n]=0 and ps_ok=1; counter cleared.
REQ-019 PWR_EN: PWR_EN=1; pg[n]=1 -> PG_DEB, counter cleared; counter reaching TIMEOUT_CYCLES-1 with pg[n]=0 -> FAULT.
REQ-020 PG_DEB: pg[n]=0 -> PWR_EN, counter cleared; counter reaching DEB_CYCLES-1 with pg[n]=1 -> RST_HOLD, counter cleared.
REQ-021 RST_HOLD: RST_DME_N=0; counter increments only while plt_ok=1 and clears while plt_ok=0; reaching RST_DLY_CYCLES-1 -> RUN.
REQ-022 RUN: RST_DME_N=1; plt_ok=0 -> RST_HOLD (RST_DME_N low the next cycle), counter cleared.
REQ-023 pg[n]=0 in RST_HOLD or RUN -> FAULT.
REQ-024 FAULT: PWR_EN=0, RST_DME_N=0, fault bit=1; sticky, left only via OFF (abs[n]=1 or ps_ok=0) or RST_SYNC.
REQ-025 PWR_EN bit SHALL be 1 in PWR_EN, PG_DEB, RST_HOLD, RUN; 0 in OFF, FAULT.
REQ-026 On PG_DEB/RST_HOLD-to-RUN transitions DMEIDLatched[n] SHALL capture DMEID[n] and ID valid SHALL set; both clear in OFF.
REQ-027 All outputs SHALL be registered; input-pin change reaches an output 3 cycles later (2 sync + 1 state).
REQ-028 Counters SHALL be $clog2(max(DEB,RST_DLY,TIMEOUT)+1) bits, saturating, never wrapping.

Reset
REQ-029 On RST_SYNC=1: all FSMs OFF, counters 0, synchronisers 0, RST_DME_N all 0, DMEControl all 0, DMEIDLatched all 0.
REQ-030 RST_SYNC mid-operation SHALL override any state in the same edge; no partial state is retained.

Structure
REQ-031 State encoding and DMEControl bit positions SHALL live in shared package dme_pkg.
REQ-032 Per-slot FSM, counter and ID latch SHALL be sub-module dme_slot_fsm, instantiated NUM_DME times by generate; synchronisers in top.

Verification (NUM_DME=2, DEB=4, RST_DLY=8, TIMEOUT=16)
REQ-033 Normal bring-up: ps_ok=1, abs=0, PWRGD slot0 high 5 cycles after PWR_EN, PLTRST_N high -> RUN, RST_DME_N[0]=1 after 4+8 cycles, DMEIDLatched[0]=DMEID[3:0] (e.g. 4'hA), ID valid=1.
REQ-034 Timeout: PWRGD slot1 held low -> FAULT at count 15, DMEControl[11:6]=6'b011010, RST_DME_N[1]=0.
REQ-035 Debounce glitch: PWRGD low 1 cycle at debounce count 2 -> back to PWR_EN, full 4-cycle debounce restarts.
REQ-036 PLTRST_N pulse low 3 cycles in RUN -> RST_DME_N low 3 cycles after pin, high again 8 cycles after sync release.
REQ-037 Absent asserted in RUN and in FAULT -> OFF, DMEControl slot=0, ID cleared; other slot unaffected.
REQ-038 RST_SYNC asserted in RUN for 1 cycle -> all outputs 0 next edge, bring-up restarts from OFF.
